// File: rtl/vertex_fetch.sv
// Vertex fetch: walks a 3*N index buffer, fetches each vertex record
// and hands it to the rasterizer over a valid/ready handshake.
module vertex_fetch #(
    parameter int READ_LATENCY      = 2,
    parameter int INDEX_ADDR_WIDTH  = 16,
    parameter int VERTEX_ADDR_WIDTH = 16
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_in,
    input  logic [15:0]                  triangle_count_in,
    output logic [INDEX_ADDR_WIDTH-1:0]  index_addr_out,
    input  logic [15:0]                  index_data_in,
    output logic [VERTEX_ADDR_WIDTH-1:0] vertex_addr_out,
    input  logic [3:0][31:0]             vertex_data_in,
    output logic                         valid_out,
    input  logic                         ready_in,
    output logic [3:0][31:0]             vertex_out,
    output logic                         busy_out,
    output logic                         done_out
);

    typedef enum logic [1:0] {
        IDLE,
        INDEX_WAIT,
        VERTEX_WAIT,
        PRESENT
    } state_t;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);
    localparam logic [INDEX_ADDR_WIDTH-1:0] ONE = 1;

    state_t                      state;
    logic [17:0]                 remaining;
    logic [INDEX_ADDR_WIDTH-1:0] pointer;
    logic [2:0]                  wait_cnt;

    // Draw sequencer: index read, vertex read, then hold until accepted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            remaining       <= '0;
            pointer         <= '0;
            wait_cnt        <= '0;
            index_addr_out  <= '0;
            vertex_addr_out <= '0;
            vertex_out      <= '0;
            valid_out       <= 1'b0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse waits a cycle.
                    if (start_in && !done_out) begin
                        remaining <= 18'(triangle_count_in) * 18'd3;
                        pointer   <= '0;
                        wait_cnt  <= '0;
                        if (triangle_count_in == 16'd0) begin
                            done_out <= 1'b1;
                        end else begin
                            index_addr_out <= '0;
                            busy_out       <= 1'b1;
                            state          <= INDEX_WAIT;
                        end
                    end
                end
                INDEX_WAIT: begin
                    if (wait_cnt == LAT) begin
                        vertex_addr_out <=
                            index_data_in[VERTEX_ADDR_WIDTH-1:0];
                        wait_cnt <= '0;
                        state    <= VERTEX_WAIT;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                VERTEX_WAIT: begin
                    if (wait_cnt == LAT) begin
                        vertex_out <= vertex_data_in;
                        valid_out  <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                PRESENT: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        remaining <= remaining - 18'd1;
                        if (remaining == 18'd1) begin
                            done_out <= 1'b1;
                            busy_out <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            pointer        <= pointer + ONE;
                            index_addr_out <= pointer + ONE;
                            wait_cnt       <= '0;
                            state          <= INDEX_WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vertex_fetch.sv
// Testbench for vertex_fetch: three latency variants fed by BRAM models,
// checked against a cycle-level model of the draw sequence.
module tb_vertex_fetch;

    typedef logic [3:0][31:0] vtx_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b1;
    logic [15:0] count = 16'd0;

    logic [15:0] ia[3];
    logic [15:0] va[3];
    logic [15:0] idat[3];
    vtx_t        vdat[3];
    vtx_t        vo[3];
    logic        valid[3];
    logic        busy[3];
    logic        done[3];

    logic [15:0] ibuf[64];
    logic [15:0] ip[3][4];
    vtx_t        vp[3][4];

    vertex_fetch #(.READ_LATENCY(2)) u_l2 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .triangle_count_in(count),
        .index_addr_out(ia[0]), .index_data_in(idat[0]),
        .vertex_addr_out(va[0]), .vertex_data_in(vdat[0]),
        .valid_out(valid[0]), .ready_in(ready), .vertex_out(vo[0]),
        .busy_out(busy[0]), .done_out(done[0])
    );

    vertex_fetch #(.READ_LATENCY(1)) u_l1 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .triangle_count_in(count),
        .index_addr_out(ia[1]), .index_data_in(idat[1]),
        .vertex_addr_out(va[1]), .vertex_data_in(vdat[1]),
        .valid_out(valid[1]), .ready_in(ready), .vertex_out(vo[1]),
        .busy_out(busy[1]), .done_out(done[1])
    );

    vertex_fetch #(.READ_LATENCY(4)) u_l4 (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .triangle_count_in(count),
        .index_addr_out(ia[2]), .index_data_in(idat[2]),
        .vertex_addr_out(va[2]), .vertex_data_in(vdat[2]),
        .valid_out(valid[2]), .ready_in(ready), .vertex_out(vo[2]),
        .busy_out(busy[2]), .done_out(done[2])
    );

    function automatic vtx_t vdata(input logic [15:0] a);
        vtx_t v;
        for (int k = 0; k < 4; k++) v[k] = {16'd0, a} + 32'(k);
        return v;
    endfunction

    // BRAM models: data for an address appears LAT cycles after it.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            ip[d][0] <= ibuf[ia[d][5:0]];
            vp[d][0] <= vdata(va[d]);
            for (int s = 1; s < 4; s++) begin
                ip[d][s] <= ip[d][s-1];
                vp[d][s] <= vp[d][s-1];
            end
        end
    end

    assign idat[0] = ip[0][1];
    assign idat[1] = ip[1][0];
    assign idat[2] = ip[2][3];
    assign vdat[0] = vp[0][1];
    assign vdat[1] = vp[1][0];
    assign vdat[2] = vp[2][3];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   cyc0 = 0;
    int   drop_at = 1;
    int   mode = 0;
    int   s0 = 0;
    int   s1 = 0;
    bit   mon = 1'b0;
    int   xc[$];
    vtx_t xv[$];
    int   dc[$];
    int   ec[$];
    vtx_t ev[$];
    int   bcount, bfirst, blast, vfirst, stall_viol;
    bit   pv, pr;
    vtx_t pvx;
    bit   rdy_hist[4096];
    int   passed = 0;
    int   total = 0;

    task automatic drive_ready(input int r);
        case (mode)
            0: ready = 1'b1;
            1: ready = ($urandom_range(0, 3) != 0);
            default: ready = !(r >= s0 && r < s1);
        endcase
    endtask

    task automatic sample();
        int r;
        r = cyc - cyc0;
        if (mon) begin
            if (r >= 0 && r < 4096) rdy_hist[r] = ready;
            if (valid[0] && ready) begin
                xc.push_back(r);
                xv.push_back(vo[0]);
            end
            if (done[0]) dc.push_back(r);
            if (busy[0]) begin
                bcount++;
                if (bfirst < 0) bfirst = r;
                blast = r;
            end
            if (valid[0] && vfirst < 0) vfirst = r;
            if (pv && !pr && (valid[0] !== 1'b1 || vo[0] !== pvx))
                stall_viol++;
            pv  = valid[0];
            pr  = ready;
            pvx = vo[0];
        end
    endtask

    task automatic step();
        int r;
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        r = cyc - cyc0;
        if (r >= drop_at) start = 1'b0;
        drive_ready(r);
    endtask

    task automatic begin_draw(input logic [15:0] n, input int drop);
        xc.delete(); xv.delete(); dc.delete();
        bcount = 0; bfirst = -1; blast = -1; vfirst = -1;
        stall_viol = 0; pv = 1'b0;
        foreach (rdy_hist[i]) rdy_hist[i] = 1'b0;
        @(posedge clk);
        #1;
        cyc0 = cyc;
        start = 1'b1;
        count = n;
        drop_at = drop;
        drive_ready(0);
        mon = 1'b1;
    endtask

    task automatic run(input int want, input int budget, input int extra,
                       output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            step();
            if (dc.size() >= want) begin
                to = 1'b0;
                break;
            end
        end
        repeat (extra) step();
        mon = 1'b0;
    endtask

    // Reference: each vertex rises 2L+3 cycles after the previous
    // transfer and transfers on the first cycle with ready high.
    task automatic build_exp(input int n, input int lat);
        int t;
        ec.delete(); ev.delete();
        t = 2 * lat + 3;
        for (int i = 0; i < 3 * n; i++) begin
            while (t < 4095 && !rdy_hist[t]) t++;
            ec.push_back(t);
            ev.push_back(vdata(ibuf[i % 64]));
            t += 2 * lat + 3;
        end
    endtask

    task automatic fill_ibuf();
        for (int i = 0; i < 64; i++) ibuf[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 0;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({valid[d], busy[d], done[d]} !== 3'b000)
                $display("FAIL reset_flags dut%0d got %b want 000",
                         d, {valid[d], busy[d], done[d]});
            else passed++;
            total++;
            if (ia[d] !== 16'd0 || va[d] !== 16'd0)
                $display("FAIL reset_addr dut%0d got %h/%h want 0/0",
                         d, ia[d], va[d]);
            else passed++;
            total++;
            if (vo[d] !== '0)
                $display("FAIL reset_vertex dut%0d got %h want 0", d, vo[d]);
            else passed++;
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero();
        logic [15:0] ia0;
        bit moved;
        ia0 = ia[0];
        moved = 1'b0;
        mode = 0;
        begin_draw(16'd0, 1);
        for (int c = 0; c < 10; c++) begin
            step();
            if (ia[0] !== ia0) moved = 1'b1;
        end
        mon = 1'b0;
        total++;
        if (dc.size() !== 1)
            $display("FAIL zero_done_count got %0d want 1", dc.size());
        else passed++;
        total++;
        if ((dc.size() > 0 ? dc[0] : -1) !== 1)
            $display("FAIL zero_done_cycle got %0d want 1",
                     dc.size() > 0 ? dc[0] : -1);
        else passed++;
        total++;
        if (vfirst !== -1 || bcount !== 0 || moved)
            $display("FAIL zero_quiet got valid@%0d busy=%0d moved=%0d want -1/0/0",
                     vfirst, bcount, moved);
        else passed++;
    endtask

    task automatic test_basic();
        bit to;
        int e[3];
        e = '{5, 2, 9};
        ibuf[0] = 16'd5; ibuf[1] = 16'd2; ibuf[2] = 16'd9;
        mode = 0;
        begin_draw(16'd1, 1);
        run(1, 200, 5, to);
        total++;
        if (to) $display("FAIL basic_timeout got no done want done");
        else passed++;
        total++;
        if (vfirst !== 7)
            $display("FAIL basic_first_valid got %0d want 7", vfirst);
        else passed++;
        total++;
        if (xc.size() !== 3)
            $display("FAIL basic_xfers got %0d want 3", xc.size());
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ((i < xc.size() ? xc[i] : -1) !== 7 * (i + 1))
                $display("FAIL basic_xfer_cycle[%0d] got %0d want %0d",
                         i, i < xc.size() ? xc[i] : -1, 7 * (i + 1));
            else passed++;
            total++;
            if ((i < xv.size() ? xv[i] : '0) !== vdata(16'(e[i])))
                $display("FAIL basic_vertex[%0d] got %h want %h", i,
                         i < xv.size() ? xv[i] : '0, vdata(16'(e[i])));
            else passed++;
        end
        total++;
        if (dc.size() !== 1 || (dc.size() > 0 ? dc[0] : -1) !== 22)
            $display("FAIL basic_done got n=%0d first=%0d want n=1 at 22",
                     dc.size(), dc.size() > 0 ? dc[0] : -1);
        else passed++;
        total++;
        if (bfirst !== 1 || blast !== 21 || bcount !== 21)
            $display("FAIL basic_busy got %0d..%0d n=%0d want 1..21 n=21",
                     bfirst, blast, bcount);
        else passed++;
    endtask

    task automatic check_list_stall();
        bit to;
        fill_ibuf();
        mode = 2; s0 = 14; s1 = 24;
        begin_draw(16'd2, 1);
        run(1, 300, 5, to);
        mode = 0;
        build_exp(2, 2);
        total++;
        if (to || xc.size() !== 6)
            $display("FAIL stall_xfers got n=%0d timeout=%0d want 6/0",
                     xc.size(), to);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ((i < xc.size() ? xc[i] : -1) !== ec[i] ||
                (i < xv.size() ? xv[i] : '0) !== ev[i])
                $display("FAIL stall_xfer[%0d] got %0d:%h want %0d:%h", i,
                         i < xc.size() ? xc[i] : -1,
                         i < xv.size() ? xv[i] : '0, ec[i], ev[i]);
            else passed++;
        end
        total++;
        if ((xc.size() > 1 ? xc[1] : -1) !== 24)
            $display("FAIL stall_second_cycle got %0d want 24",
                     xc.size() > 1 ? xc[1] : -1);
        else passed++;
        total++;
        if (stall_viol !== 0)
            $display("FAIL stall_stable got %0d changes want 0", stall_viol);
        else passed++;
        total++;
        if (dc.size() !== 1 || (dc.size() > 0 ? dc[0] : -1) !== ec[5] + 1)
            $display("FAIL stall_done got n=%0d at %0d want n=1 at %0d",
                     dc.size(), dc.size() > 0 ? dc[0] : -1, ec[5] + 1);
        else passed++;
    endtask

    task automatic test_start_ignored();
        bit to;
        fill_ibuf();
        mode = 0;
        begin_draw(16'd2, 1);
        repeat (10) step();
        start = 1'b1;
        count = 16'd7;
        step();
        run(1, 300, 30, to);
        build_exp(2, 2);
        total++;
        if (to || xc.size() !== 6)
            $display("FAIL ignore_xfers got n=%0d timeout=%0d want 6/0",
                     xc.size(), to);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if ((i < xc.size() ? xc[i] : -1) !== ec[i] ||
                (i < xv.size() ? xv[i] : '0) !== ev[i])
                $display("FAIL ignore_xfer[%0d] got %0d:%h want %0d:%h", i,
                         i < xc.size() ? xc[i] : -1,
                         i < xv.size() ? xv[i] : '0, ec[i], ev[i]);
            else passed++;
        end
        total++;
        if (dc.size() !== 1)
            $display("FAIL ignore_done got %0d want 1", dc.size());
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit to;
        int want;
        fill_ibuf();
        mode = 0;
        begin_draw(16'd1, 40);
        run(2, 300, 5, to);
        total++;
        if (to || dc.size() !== 2 ||
            dc[0] !== 22 || dc[1] !== 45)
            $display("FAIL b2b_done got n=%0d timeout=%0d want 22,45",
                     dc.size(), to);
        else passed++;
        total++;
        if (xc.size() !== 6)
            $display("FAIL b2b_xfers got %0d want 6", xc.size());
        else passed++;
        for (int i = 0; i < 6; i++) begin
            want = (i < 3) ? 7 * (i + 1) : 23 + 7 * (i - 2);
            total++;
            if ((i < xc.size() ? xc[i] : -1) !== want ||
                (i < xv.size() ? xv[i] : '0) !== vdata(ibuf[i % 3]))
                $display("FAIL b2b_xfer[%0d] got %0d:%h want %0d:%h", i,
                         i < xc.size() ? xc[i] : -1,
                         i < xv.size() ? xv[i] : '0, want,
                         vdata(ibuf[i % 3]));
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        fill_ibuf();
        mode = 0;
        begin_draw(16'd3, 1);
        repeat (15) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (valid[0] !== 1'b0 || busy[0] !== 1'b0)
            $display("FAIL rstmid_idle got valid=%b busy=%b want 0/0",
                     valid[0], busy[0]);
        else passed++;
        repeat (14) step();
        mon = 1'b0;
        total++;
        if (xc.size() !== 2 || dc.size() !== 0)
            $display("FAIL rstmid_abandon got xfers=%0d dones=%0d want 2/0",
                     xc.size(), dc.size());
        else passed++;
        begin_draw(16'd1, 1);
        run(1, 200, 5, to);
        build_exp(1, 2);
        total++;
        if (to || xc.size() !== 3 || dc[0] !== 22)
            $display("FAIL rstmid_redraw got n=%0d timeout=%0d want 3/0",
                     xc.size(), to);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ((i < xc.size() ? xc[i] : -1) !== ec[i] ||
                (i < xv.size() ? xv[i] : '0) !== ev[i])
                $display("FAIL rstmid_xfer[%0d] got %0d:%h want %0d:%h", i,
                         i < xc.size() ? xc[i] : -1,
                         i < xv.size() ? xv[i] : '0, ec[i], ev[i]);
            else passed++;
        end
    endtask

    task automatic test_latency();
        int   fv[3];
        int   dn[3];
        int   nx[3];
        vtx_t got[3][3];
        int   want_fv[3];
        int   want_dn[3];
        want_fv = '{0, 5, 11};
        want_dn = '{0, 16, 34};
        fill_ibuf();
        mode = 0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int d = 0; d < 3; d++) begin
            fv[d] = -1; dn[d] = -1; nx[d] = 0;
            for (int i = 0; i < 3; i++) got[d][i] = '0;
        end
        begin_draw(16'd1, 1);
        for (int c = 0; c < 45; c++) begin
            for (int d = 1; d < 3; d++) begin
                if (valid[d] && fv[d] < 0) fv[d] = c;
                if (valid[d] && ready) begin
                    if (nx[d] < 3) got[d][nx[d]] = vo[d];
                    nx[d]++;
                end
                if (done[d] && dn[d] < 0) dn[d] = c;
            end
            step();
        end
        mon = 1'b0;
        for (int d = 1; d < 3; d++) begin
            total++;
            if (fv[d] !== want_fv[d] || dn[d] !== want_dn[d])
                $display("FAIL lat_dut%0d_timing got %0d/%0d want %0d/%0d",
                         d, fv[d], dn[d], want_fv[d], want_dn[d]);
            else passed++;
            total++;
            if (nx[d] !== 3)
                $display("FAIL lat_dut%0d_xfers got %0d want 3", d, nx[d]);
            else passed++;
            for (int i = 0; i < 3; i++) begin
                total++;
                if (got[d][i] !== vdata(ibuf[i]))
                    $display("FAIL lat_dut%0d_vertex[%0d] got %h want %h",
                             d, i, got[d][i], vdata(ibuf[i]));
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        bit to;
        int n;
        for (int it = 0; it < 6; it++) begin
            fill_ibuf();
            n = $urandom_range(1, 4);
            mode = 1;
            begin_draw(16'(n), 1);
            run(1, 3000, 5, to);
            mode = 0;
            build_exp(n, 2);
            total++;
            if (to || xc.size() !== ec.size())
                $display("FAIL rand%0d_xfers got n=%0d timeout=%0d want %0d",
                         it, xc.size(), to, ec.size());
            else passed++;
            for (int i = 0; i < ec.size(); i++) begin
                total++;
                if ((i < xc.size() ? xc[i] : -1) !== ec[i] ||
                    (i < xv.size() ? xv[i] : '0) !== ev[i])
                    $display("FAIL rand%0d_xfer[%0d] got %0d:%h want %0d:%h",
                             it, i, i < xc.size() ? xc[i] : -1,
                             i < xv.size() ? xv[i] : '0, ec[i], ev[i]);
                else passed++;
            end
            total++;
            if (stall_viol !== 0 || dc.size() !== 1 ||
                (dc.size() > 0 ? dc[0] : -1) !== ec[ec.size()-1] + 1)
                $display("FAIL rand%0d_done got n=%0d at %0d viol=%0d want 1 at %0d",
                         it, dc.size(), dc.size() > 0 ? dc[0] : -1,
                         stall_viol, ec[ec.size()-1] + 1);
            else passed++;
        end
    endtask

    initial begin
        fill_ibuf();
        test_reset();
        test_zero();
        test_basic();
        check_list_stall();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_latency();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vertex_fetch.md
Name: vertex_fetch

Overview:
- Producer side of the rasterizer's vertex handshake (valid/ready, 4x32-bit vertex word).
- On a start command, walks an index buffer of 3*N entries. For each entry it reads a vertex record from the vertex buffer, then presents that record downstream one vertex at a time.
- Sits between the index/vertex BRAMs and the rasterizer. Every three accepted vertices form one triangle.

Parameters:
- READ_LATENCY, 2, cycles from address presented to data valid on both BRAM read ports (legal range 1..4).
- INDEX_ADDR_WIDTH, 16, index buffer address width.
- VERTEX_ADDR_WIDTH, 16, vertex buffer address width; a fetched index is truncated to this width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous reset, active-high.
- start_in  input  1  begin a draw; sampled only in Idle.
- triangle_count_in  input  16  number of triangles N; latched on accepted start.
- index_addr_out  output  INDEX_ADDR_WIDTH  index buffer read address (registered).
- index_data_in  input  16  index buffer read data.
- vertex_addr_out  output  VERTEX_ADDR_WIDTH  vertex buffer read address (registered).
- vertex_data_in  input  [3:0][31:0]  vertex record: x, y, z, w as IEEE-754 single.
- valid_out  output  1  vertex_out holds a valid vertex.
- ready_in  input  1  downstream accepts the vertex.
- vertex_out  output  [3:0][31:0]  vertex to the rasterizer.
- busy_out  output  1  a draw is in progress.
- done_out  output  1  one-cycle pulse when the draw completes.

Behaviour:
- Reset values: state Idle; valid_out, busy_out, done_out = 0; index_addr_out, vertex_addr_out, vertex_out = 0; internal counters = 0.
- States: Idle, IndexWait, VertexWait, Present.
- Idle:
  - On start_in, latch remaining = 3*N (18-bit) and set index pointer = 0.
  - If N == 0: go straight to Idle with done_out pulsed next cycle; valid_out never rises.
  - Otherwise: set index_addr_out = 0, busy_out = 1, go to IndexWait.
- IndexWait:
  - index_addr_out is first presented in cycle c; index_data_in is sampled in cycle c+READ_LATENCY.
  - On that sample, set vertex_addr_out = index_data_in[VERTEX_ADDR_WIDTH-1:0] and go to VertexWait.
- VertexWait:
  - Same timing rule as IndexWait.
  - On the sample, load vertex_out = vertex_data_in, set valid_out = 1, go to Present.
- Present:
  - vertex_out and valid_out are held stable while valid_out && !ready_in.
  - A transfer occurs in any cycle with valid_out && ready_in. In that cycle, drop valid_out next cycle and decrement remaining.
  - If remaining was 1: go to Idle, pulse done_out, clear busy_out.
  - Otherwise: increment the index pointer, drive index_addr_out = pointer+1, go to IndexWait.
- Timing with start in cycle 0 and ready_in held high:
  - First valid_out asserts in cycle 2*READ_LATENCY+3.
  - Successive transfers are 2*READ_LATENCY+3 cycles apart.
  - done_out pulses in the cycle after the final transfer.
- ready_in is ignored when valid_out = 0. valid_out never depends combinationally on ready_in.
- start_in while busy_out = 1 is ignored; triangle_count_in is not re-sampled.
- start_in in the same cycle as done_out is not accepted. It is accepted on the next cycle if still high.
- The index pointer wraps modulo 2^INDEX_ADDR_WIDTH; no error is flagged.
- Reset mid-draw:
  - Returns to Idle next cycle with valid_out = 0, busy_out = 0.
  - No done_out pulse.
  - The partially delivered triangle is abandoned; the downstream reset is responsible for clearing its own partial state.

Test Plan:
- READ_LATENCY=2, N=1, index buffer {5,2,9}, vertex[k] = {k,k+1,k+2,k+3}, ready_in=1, start in cycle 0 -> valid_out high in cycles 7, 14, 21 carrying vertex 5, 2, 9; done_out pulses in cycle 22 only; busy_out high cycles 1..21.
- N=0 start -> done_out pulse in cycle 1; valid_out and index_addr_out never change.
- N=2, ready_in low for 10 cycles after the second valid_out -> vertex_out stable across the stall; exactly 6 transfers in index order; single done_out.
- start_in pulsed mid-draw with triangle_count_in=7 -> ignored; draw of the original N completes with 3N transfers.
- rst_in asserted one cycle after the second transfer of N=3 -> next cycle valid_out=0, busy_out=0, no done_out. A new start with N=1 then delivers indices 0..2 from the buffer start.
- READ_LATENCY=1 and 4 variants -> first valid_out in cycle 5 and 11 respectively; data matches the buffer contents.
